// File: rtl/pipe_ctrl_if.sv
// Control bundle between the Y86-64 datapath and pipe_ctrl.
// master = controller side, slave = datapath side.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;
    logic             F_stall;
    logic             D_stall;
    logic             W_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_bubble;
    logic             set_cc;
    logic             halted;
    logic [2:0]       final_stat;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mp_cnt;

    modport master (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM,
        input  e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, W_stall,
        output D_bubble, E_bubble, M_bubble, W_bubble,
        output set_cc, halted, final_stat,
        output cycle_cnt, lu_cnt, mp_cnt
    );

    modport slave (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM,
        output e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, W_stall,
        input  D_bubble, E_bubble, M_bubble, W_bubble,
        input  set_cc, halted, final_stat,
        input  cycle_cnt, lu_cnt, mp_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, flush/run/halt
// sequencing and saturating performance counters.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 5,
    parameter int CNT_W        = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.master   bus
);
    typedef enum logic [1:0] {
        S_FLUSH,
        S_RUN,
        S_HALTED
    } state_t;

    localparam logic [2:0] AOK    = 3'd1;
    localparam logic [2:0] HLT    = 3'd2;
    localparam logic [2:0] ADR    = 3'd3;
    localparam logic [2:0] INS    = 3'd4;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_MRM  = 4'h5;
    localparam logic [3:0] I_RET  = 4'h9;
    localparam logic [3:0] I_POPQ = 4'hB;
    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             halted_q, halted_d;
    logic [2:0]       fstat_q, fstat_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] lu_q, lu_d;
    logic [CNT_W-1:0] mp_q, mp_d;

    logic lu, mp, rt, mx, wx;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        lu = (bus.E_icode == I_MRM || bus.E_icode == I_POPQ)
          && bus.E_dstM != RNONE
          && (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
        mp = bus.E_icode == I_JXX && !bus.e_Cnd;
        rt = bus.D_icode == I_RET || bus.E_icode == I_RET
          || bus.M_icode == I_RET;
        mx = bus.m_stat == ADR || bus.m_stat == INS
          || bus.m_stat == HLT;
        wx = bus.W_stat != AOK;
    end

    always_comb begin
        bus.F_stall  = 1'b0;
        bus.D_stall  = 1'b0;
        bus.W_stall  = 1'b0;
        bus.D_bubble = 1'b0;
        bus.E_bubble = 1'b0;
        bus.M_bubble = 1'b0;
        bus.W_bubble = 1'b0;
        bus.set_cc   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (wx) begin
                    bus.F_stall  = 1'b1;
                    bus.D_stall  = 1'b1;
                    bus.W_stall  = 1'b1;
                    bus.E_bubble = 1'b1;
                    bus.M_bubble = 1'b1;
                end else begin
                    bus.F_stall  = lu | rt;
                    bus.D_stall  = lu;
                    bus.D_bubble = mp | (!lu & rt);
                    bus.E_bubble = mp | lu;
                    bus.M_bubble = mx;
                    bus.set_cc   = bus.E_icode == I_OPQ && !mx;
                end
            end
            S_HALTED: begin
                bus.F_stall  = 1'b1;
                bus.D_stall  = 1'b1;
                bus.W_stall  = 1'b1;
                bus.E_bubble = 1'b1;
                bus.M_bubble = 1'b1;
            end
            default: begin
                bus.F_stall  = 1'b1;
                bus.D_bubble = 1'b1;
                bus.E_bubble = 1'b1;
                bus.M_bubble = 1'b1;
                bus.W_bubble = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        halted_d = halted_q;
        fstat_d  = fstat_q;
        cyc_d    = cyc_q;
        lu_d     = lu_q;
        mp_d     = mp_q;
        case (state_q)
            S_FLUSH: begin
                fcnt_d = fcnt_q - 4'd1;
                if (fcnt_q <= 4'd1) state_d = S_RUN;
            end
            S_RUN: begin
                // The halting edge must not bump any counter.
                if (wx) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                    fstat_d  = bus.W_stat;
                end else begin
                    cyc_d = sat_inc(cyc_q);
                    if (lu) lu_d = sat_inc(lu_q);
                    if (mp) mp_d = sat_inc(mp_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FLUSH;
            fcnt_q   <= FLUSH_INIT;
            halted_q <= 1'b0;
            fstat_q  <= AOK;
            cyc_q    <= '0;
            lu_q     <= '0;
            mp_q     <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            halted_q <= halted_d;
            fstat_q  <= fstat_d;
            cyc_q    <= cyc_d;
            lu_q     <= lu_d;
            mp_q     <= mp_d;
        end
    end

    assign bus.halted     = halted_q;
    assign bus.final_stat = fstat_q;
    assign bus.cycle_cnt  = cyc_q;
    assign bus.lu_cnt     = lu_q;
    assign bus.mp_cnt     = mp_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: spec-level reference model feeding a scoreboard
// queue, narrow counters so saturation is reachable.
module tb_pipe_ctrl;
    localparam int CW = 6;
    localparam int FC = 5;

    typedef struct {
        logic [8:0]    ctl;
        logic [2:0]    fstat;
        logic [CW-1:0] cyc;
        logic [CW-1:0] lu;
        logic [CW-1:0] mp;
    } exp_t;

    logic clk;
    logic rst;
    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t exp_q[$];

    // model state: 0 flush, 1 run, 2 halted
    int            m_mode;
    int            m_fcnt;
    logic [2:0]    m_fstat;
    logic [CW-1:0] m_cyc, m_lu, m_mp;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_mode  = 0;
        m_fcnt  = FC;
        m_fstat = 3'd1;
        m_cyc   = '0;
        m_lu    = '0;
        m_mp    = '0;
    endfunction

    function automatic bit f_lu();
        return (bus.E_icode == 4'h5 || bus.E_icode == 4'hB)
            && bus.E_dstM != 4'hF
            && (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
    endfunction

    function automatic bit f_mp();
        return bus.E_icode == 4'h7 && bus.e_Cnd == 1'b0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit lu, mp, rt, mx;
        lu = f_lu();
        mp = f_mp();
        rt = bus.D_icode == 4'h9 || bus.E_icode == 4'h9
          || bus.M_icode == 4'h9;
        mx = bus.m_stat inside {3'd2, 3'd3, 3'd4};
        e.fstat = m_fstat;
        e.cyc = m_cyc;
        e.lu  = m_lu;
        e.mp  = m_mp;
        // {F_stall,D_stall,W_stall,D_bub,E_bub,M_bub,W_bub,set_cc,halted}
        if (m_mode == 0) e.ctl = 9'b100111100;
        else if (m_mode == 2) e.ctl = 9'b111011001;
        else if (bus.W_stat != 3'd1) e.ctl = 9'b111011000;
        else e.ctl = {lu | rt, lu, 1'b0, mp | (!lu & rt), mp | lu,
                      mx, 1'b0, bus.E_icode == 4'h6 && !mx, 1'b0};
        return e;
    endfunction

    function automatic void model_tick();
        if (m_mode == 0) begin
            m_fcnt--;
            if (m_fcnt == 0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.W_stat != 3'd1) begin
                m_mode  = 2;
                m_fstat = bus.W_stat;
            end else begin
                if (m_cyc != '1) m_cyc++;
                if (f_lu() && m_lu != '1) m_lu++;
                if (f_mp() && m_mp != '1) m_mp++;
            end
        end
    endfunction

    task automatic check_now(input string tag);
        exp_t e;
        exp_q.push_back(model_out());
        #1;
        e = exp_q.pop_front();
        chk({tag, ".ctl"}, 32'({bus.F_stall, bus.D_stall, bus.W_stall,
            bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_bubble,
            bus.set_cc, bus.halted}), 32'(e.ctl));
        chk({tag, ".fstat"}, 32'(bus.final_stat), 32'(e.fstat));
        chk({tag, ".cyc"}, 32'(bus.cycle_cnt), 32'(e.cyc));
        chk({tag, ".lu"}, 32'(bus.lu_cnt), 32'(e.lu));
        chk({tag, ".mp"}, 32'(bus.mp_cnt), 32'(e.mp));
    endtask

    task automatic drive(input logic [3:0] di, sa, sb, ei, edm,
                         input logic ec, input logic [3:0] mi,
                         input logic [2:0] ms, ws);
        bus.D_icode = di;
        bus.d_srcA  = sa;
        bus.d_srcB  = sb;
        bus.E_icode = ei;
        bus.E_dstM  = edm;
        bus.e_Cnd   = ec;
        bus.M_icode = mi;
        bus.m_stat  = ms;
        bus.W_stat  = ws;
    endtask

    // Called just after a negedge; leaves time just after the next negedge.
    task automatic step(input string tag, input logic [3:0] di, sa, sb,
                        ei, edm, input logic ec, input logic [3:0] mi,
                        input logic [2:0] ms, ws);
        drive(di, sa, sb, ei, edm, ec, mi, ms, ws);
        check_now(tag);
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        model_reset();
        check_now(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        model_reset();
        @(negedge clk);
        check_now("rst");
        rst = 1'b0;
        for (int i = 0; i < FC + 1; i++) idle("flush");

        for (int i = 0; i < 3; i++)
            step("lu", 4'h6, 4'h3, 4'h7, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1);
        step("lu_none", 4'h6, 4'hF, 4'h7, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        step("mp", 4'h6, 4'h1, 4'h2, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
        step("mp_rt", 4'h9, 4'h1, 4'h2, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
        step("lu_rt", 4'h9, 4'h1, 4'h2, 4'hB, 4'h2, 1'b1, 4'h1, 3'd1, 3'd1);
        step("rt_m", 4'h1, 4'h1, 4'h2, 4'h6, 4'hF, 1'b1, 4'h9, 3'd1, 3'd1);
        step("mx", 4'h1, 4'h1, 4'h2, 4'h6, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1);
        step("mx_hlt", 4'h1, 4'h1, 4'h2, 4'h6, 4'hF, 1'b1, 4'h1, 3'd2, 3'd1);

        for (int i = 0; i < 80; i++) begin
            logic [3:0] ic;
            logic [3:0] set_e [6];
            logic [2:0] set_m [6];
            set_e = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
            set_m = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
            ic = set_e[$urandom_range(0, 5)];
            step("rand", set_e[$urandom_range(0, 5)],
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ic, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 set_e[$urandom_range(0, 5)], set_m[$urandom_range(0, 5)],
                 3'd1);
        end

        step("wx", 4'h9, 4'h5, 4'h5, 4'h5, 4'h5, 1'b0, 4'h1, 3'd3, 3'd3);
        for (int i = 0; i < 4; i++)
            step("halt_tog", 4'($urandom_range(0, 15)), 4'h2, 4'h3,
                 4'h7, 4'h2, 1'b0, 4'h9, 3'd4, 3'(i));
        chk("halted_lvl", 32'(bus.halted), 32'd1);
        chk("final_stat_lvl", 32'(bus.final_stat), 32'd3);

        async_reset("arst_halt");
        chk("arst_fstat", 32'(bus.final_stat), 32'd1);
        for (int i = 0; i < FC; i++) idle("reflush");
        for (int i = 0; i < 2; i++)
            step("lu2", 4'h6, 4'h4, 4'h9, 4'hB, 4'h9, 1'b1, 4'h1, 3'd1, 3'd1);
        drive(4'h6, 4'h4, 4'h9, 4'hB, 4'h9, 1'b1, 4'h1, 3'd1, 3'd1);
        async_reset("arst_stall");
        for (int i = 0; i < FC + 2; i++) idle("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
